// File: rtl/ultrasonic_echo_emulator_pkg.sv
// Shared types and default timing constants for the ultrasonic echo emulator.
// Optional feature macro: ULTRASONIC_JITTER_EN (see ultrasonic_echo_emulator.sv).
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

  localparam int DEF_CYCLES_PER_CM  = 2900;
  localparam int DEF_TRIG_MIN       = 500;
  localparam int DEF_BURST_CYCLES   = 10000;
  localparam int DEF_MAX_CM         = 400;
  localparam int DEF_TIMEOUT_CYCLES = 1900000;
  localparam int DEF_HOLDOFF_CYCLES = 500000;

  localparam int MIN_CM = 2;
  localparam int CNT_W  = 21;
  localparam int DIST_W = 9;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // x^8 + x^6 + x^5 + x^4 + 1, maximal length over the 255 non-zero states
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/ultrasonic_echo_emulator_if.sv
// Ranging link between the measurement initiator (master) and the echo emulator (slave).
interface ultrasonic_echo_emulator_if;
  import ultrasonic_pkg::*;

  logic              trigger;
  logic [DIST_W-1:0] distance_cm;
  logic              echo;
  logic              busy;
  logic              done;
  logic              trig_err;

  modport master (
    output trigger, distance_cm,
    input  echo, busy, done, trig_err
  );

  modport slave (
    input  trigger, distance_cm,
    output echo, busy, done, trig_err
  );

endinterface

// File: rtl/ultrasonic_echo_emulator_trigger_qualifier.sv
// Synchronizes the asynchronous trigger and measures its high time; emits a
// one-cycle qual (long enough) or registered short (too short) on each falling edge.
module trigger_qualifier #(
  parameter int TRIG_MIN = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic trig_i,
  input  logic arm_i,
  output logic qual_o,
  output logic short_o
);

  localparam int HW = $clog2(TRIG_MIN + 1);

  logic          sync1_q, trig_s_q, trig_prev_q;
  logic [HW-1:0] high_q, high_d;
  logic          short_q, short_d;
  logic          fall, long_enough;

  assign fall        = trig_prev_q & ~trig_s_q;
  assign long_enough = high_q >= HW'(TRIG_MIN);

  // Counter is held at zero while disarmed so a trigger already high at IDLE entry counts from 0
  always_comb begin
    high_d = high_q;
    if (!arm_i || !trig_s_q)
      high_d = '0;
    else if (!long_enough)
      high_d = high_q + HW'(1);
  end

  assign qual_o  = arm_i & fall & long_enough;
  assign short_d = arm_i & fall & ~long_enough;
  assign short_o = short_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
      high_q      <= '0;
      short_q     <= 1'b0;
    end else begin
      sync1_q     <= trig_i;
      trig_s_q    <= sync1_q;
      trig_prev_q <= trig_s_q;
      high_q      <= high_d;
      short_q     <= short_d;
    end
  end

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style echo responder: qualified trigger -> burst delay -> echo of d*CYCLES_PER_CM -> holdoff.
// Define ULTRASONIC_JITTER_EN to add 0..255 cycles of LFSR jitter to every echo width.
module ultrasonic_echo_emulator
  import ultrasonic_pkg::*;
#(
  parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
  parameter int TRIG_MIN       = DEF_TRIG_MIN,
  parameter int BURST_CYCLES   = DEF_BURST_CYCLES,
  parameter int MAX_CM         = DEF_MAX_CM,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input logic                        clk,
  input logic                        reset,
  ultrasonic_echo_emulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESC_LAST   = CNT_W'(CYCLES_PER_CM - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              tmo_q, tmo_d;
  logic              echo_q, echo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              qual, short_pulse;
  logic              base_en, echo_fin;

`ifdef ULTRASONIC_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] jit_q, jit_d;
`endif

  trigger_qualifier #(
    .TRIG_MIN (TRIG_MIN)
  ) u_qual (
    .clk     (clk),
    .reset   (reset),
    .trig_i  (bus.trigger),
    .arm_i   (state_q == ST_IDLE),
    .qual_o  (qual),
    .short_o (short_pulse)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cm_d     = cm_q;
    dist_d   = dist_q;
    tmo_d    = tmo_q;
    echo_d   = echo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    base_en  = 1'b1;
    echo_fin = 1'b0;
`ifdef ULTRASONIC_JITTER_EN
    lfsr_d   = lfsr_q;
    jit_d    = jit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (qual) begin
          state_d = ST_BURST;
          busy_d  = 1'b1;
          cnt_d   = '0;
          cm_d    = '0;
          tmo_d   = int'(bus.distance_cm) > MAX_CM;
          dist_d  = (int'(bus.distance_cm) < MIN_CM) ? DIST_W'(MIN_CM) : bus.distance_cm;
`ifdef ULTRASONIC_JITTER_EN
          jit_d   = lfsr_q;
          lfsr_d  = lfsr_next(lfsr_q);
`endif
        end
      end
      ST_BURST: begin
        if (cnt_q == BURST_LAST) begin
          cnt_d   = '0;
          state_d = ST_ECHO;
          echo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ECHO: begin
`ifdef ULTRASONIC_JITTER_EN
        // Jitter cycles are spent first, then the nominal width
        base_en = (jit_q == 8'd0);
        if (!base_en)
          jit_d = jit_q - 8'd1;
`endif
        if (base_en) begin
          if (tmo_q) begin
            if (cnt_q == TIMEOUT_LAST) echo_fin = 1'b1;
            else                       cnt_d = cnt_q + CNT_W'(1);
          end else if (cnt_q == PRESC_LAST) begin
            cnt_d = '0;
            if (cm_q == dist_q - DIST_W'(1)) echo_fin = 1'b1;
            else                             cm_d = cm_q + DIST_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (echo_fin) begin
          echo_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cm_q    <= '0;
      dist_q  <= '0;
      tmo_q   <= 1'b0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ULTRASONIC_JITTER_EN
      lfsr_q  <= LFSR_SEED;
      jit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cm_q    <= cm_d;
      dist_q  <= dist_d;
      tmo_q   <= tmo_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ULTRASONIC_JITTER_EN
      lfsr_q  <= lfsr_d;
      jit_q   <= jit_d;
`endif
    end
  end

  assign bus.echo     = echo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.trig_err = short_pulse;

endmodule

// File: doc/ultrasonic_echo_emulator.md
# ultrasonic_echo_emulator

Responder side of the HC-SR04-style ranging interface: watches the `trigger` line driven by the ultrasonic measurement block, qualifies the pulse width, waits a fixed transducer-burst delay, then drives `echo` high for a width proportional to a programmed distance in centimetres. It stands in for the physical sensor in simulation and on-board loopback tests, so the display/measurement path can be exercised with known distances.

## Interface
- `CYCLES_PER_CM`, 2900: clk cycles of echo per cm (58 µs at 50 MHz).
- `TRIG_MIN`, 500: minimum qualified trigger high time in cycles (10 µs).
- `BURST_CYCLES`, 10000: delay from qualified trigger fall to echo rise (200 µs).
- `MAX_CM`, 400: largest in-range distance.
- `TIMEOUT_CYCLES`, 1900000: echo width for out-of-range distance (38 ms).
- `HOLDOFF_CYCLES`, 500000: dead time after echo falls (10 ms).
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `trigger` in 1: asynchronous trigger from the initiator.
- `distance_cm` in 9: distance to emulate, sampled at qualification.
- `echo` out 1: echo pulse to the initiator.
- `busy` out 1: high from qualification until holdoff ends.
- `done` out 1: one-cycle pulse when echo falls.
- `trig_err` out 1: one-cycle pulse on a too-short trigger.

## Operation
- Reset (`reset`=0): `echo`=0, `busy`=0, `done`=0, `trig_err`=0, FSM in IDLE, all counters 0, synchronizer flops 0. Takes effect immediately, including mid-echo.
- `trigger` passes a 2-flop synchronizer; all decisions use the synchronized value `trig_s`.
- States: IDLE, BURST, ECHO, HOLDOFF.
- IDLE: high-time counter increments while `trig_s`=1, saturating at `TRIG_MIN`; cleared while `trig_s`=0. On `trig_s` falling edge: count ≥ `TRIG_MIN` → latch `distance_cm`, `busy`=1, go BURST; else pulse `trig_err`, stay IDLE.
- BURST: `echo`=0 for exactly `BURST_CYCLES` cycles, then ECHO.
- ECHO: `echo`=1 for exactly W cycles. W = d·`CYCLES_PER_CM`, d = latched distance clamped below to 2; d > `MAX_CM` → W = `TIMEOUT_CYCLES`. W is produced by nested counters (cycle prescaler 0..`CYCLES_PER_CM`-1, cm counter to d); no multiplier. Exit: `echo`=0, `done`=1 for one cycle, go HOLDOFF.
- HOLDOFF: `HOLDOFF_CYCLES` cycles, then IDLE, `busy`=0.
- Trigger activity in BURST/ECHO/HOLDOFF is ignored. On return to IDLE with `trig_s` already high, the high-time counter starts from 0 at IDLE entry; a pulse is qualified only on its falling edge with full count.
- `distance_cm` changes after latching do not affect the current pulse.
- Counter widths: 21 bits for echo/timeout/holdoff, sized for defaults; parameters exceeding 2^21-1 are unsupported.

## Timing
- Trigger-to-logic latency: 2 cycles (synchronizer).
- `trig_s` fall observed at cycle t → state BURST at t+1; `echo` rises at t+1+`BURST_CYCLES`.
- `echo` high exactly W cycles, registered output, no glitches.
- `done` asserted in the first cycle `echo` is 0; `trig_err` one cycle after the failing fall.
- Minimum trigger period accepted: BURST+W+HOLDOFF plus trigger high time.

## Configuration
- `ULTRASONIC_JITTER_EN` defined: 8-bit maximal LFSR (seed 8'hA5 on reset, advanced once per qualified trigger) adds its value 0..255 cycles to W, modelling acoustic noise; applies to timeout width too.
- Not defined: W exactly as above; no LFSR logic present.

## Structure
- Package `ultrasonic_pkg`: FSM state enum, default constants (2900, 500, 10000, 400, 1900000, 500000), min-distance constant 2, LFSR seed.
- Sub-module `trigger_qualifier`: synchronizer, high-time counter, emits one-cycle `qual` / `short` pulses to the FSM.

## Test plan
Bench parameters: `CYCLES_PER_CM`=10, `TRIG_MIN`=5, `BURST_CYCLES`=20, `MAX_CM`=400, `TIMEOUT_CYCLES`=5000, `HOLDOFF_CYCLES`=30; macro undefined unless stated.
- Trigger high 6 cycles, `distance_cm`=25 → echo rises 20 cycles after state BURST, stays high exactly 250 cycles, `done` one pulse, `busy` low 30 cycles later.
- Trigger high 3 cycles → `trig_err` one pulse, `echo` and `busy` stay 0.
- `distance_cm`=401 → echo width 5000; `distance_cm`=0 and 1 → width 20.
- Second trigger during ECHO plus `distance_cm` changed 25→100 mid-pulse → width still 250, no second echo.
- `reset` low mid-ECHO → `echo`, `busy` 0 in the same cycle; next valid trigger with d=10 gives width 100.
- `ULTRASONIC_JITTER_EN` defined, d=25, 20 triggers → every width in [250, 505], not all equal, sequence repeats after reset.
